// File: rtl/lpf_pkg.sv
// Shared constants and the round/saturate helper for the LPF output requantiser.
// The same helper serves as the reference model in the filter testbench.
package lpf_pkg;

  localparam int LPF_IN_W  = 18;
  localparam int LPF_OUT_W = 8;
  localparam int LPF_SHIFT = 9;

  localparam logic [LPF_OUT_W-1:0] LPF_SAT_MAX = '1;

  // Round half up, then clamp to the output range; one extra bit keeps the add exact.
  function automatic logic [LPF_OUT_W-1:0] lpf_round_sat(input logic [LPF_IN_W-1:0] x);
    logic [LPF_IN_W:0] sum;
    logic [LPF_IN_W:0] r;
    sum = {1'b0, x} + ((LPF_IN_W+1)'(1) << (LPF_SHIFT - 1));
    r   = sum >> LPF_SHIFT;
    if (r > (LPF_IN_W+1)'(LPF_SAT_MAX)) begin
      return LPF_SAT_MAX;
    end
    return r[LPF_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/lpf_decim_requant_if.sv
// Valid/ready output stream from the requantiser toward the downstream sink.
interface lpf_decim_requant_if #(
  parameter int width = 8
);
  logic [width-1:0] Data_out;
  logic             out_valid;
  logic             out_ready;

  modport master (output Data_out, output out_valid, input out_ready);
  modport slave  (input Data_out, input out_valid, output out_ready);
endinterface

// File: rtl/lpf_sync_fifo.sv
// Small synchronous FIFO with an unregistered head read; a push while full is
// accepted only when a pop happens on the same edge.
module lpf_sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             wdata,
  output logic [width-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(depth));
  assign count   = count_reg;
  assign rdata   = mem[rd_ptr_reg];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/lpf_decim_requant.sv
// Decimates the 18-bit filter stream, rounds/saturates kept samples to 8 bits and
// queues them for the sink. Define LPF_DROP_COUNT_EN to add the drop_count port.
module lpf_decim_requant
  import lpf_pkg::*;
#(
  parameter int word_size_in  = LPF_IN_W,
  parameter int word_size_out = LPF_OUT_W,
  parameter int shift         = LPF_SHIFT,
  parameter int decim         = 4,
  parameter int fifo_depth    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [word_size_in-1:0] Data_in,
  input  logic                    in_valid,
  lpf_decim_requant_if.master     sink,
  output logic                    overflow,
  input  logic                    clear_ovf
`ifdef LPF_DROP_COUNT_EN
  ,
  output logic [7:0]              drop_count
`endif
);

  localparam int SUM_W = word_size_in + 1;
  localparam int CW    = $clog2(fifo_depth + 1);
  localparam logic [SUM_W-1:0]         HALF    = SUM_W'(1) << (shift - 1);
  localparam logic [SUM_W-1:0]         MAX_WIDE = SUM_W'((1 << word_size_out) - 1);
  localparam logic [word_size_out-1:0] MAX_OUT  = '1;

  logic [3:0]               phase_reg;
  logic                     keep;
  logic [SUM_W-1:0]         sum;
  logic [SUM_W-1:0]         rq;
  logic [word_size_out-1:0] sat;
  logic                     s1_valid_reg;
  logic [word_size_out-1:0] s1_data_reg;
  logic                     overflow_reg;
  logic                     drop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [word_size_out-1:0] fifo_rdata;

  assign keep = in_valid && (phase_reg == 4'd0);
  assign sum  = {1'b0, Data_in} + HALF;
  assign rq   = sum >> shift;
  assign sat  = (rq > MAX_WIDE) ? MAX_OUT : rq[word_size_out-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_reg    <= 4'd0;
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
    end else begin
      if (in_valid) begin
        phase_reg <= (phase_reg == 4'(decim - 1)) ? 4'd0 : phase_reg + 4'd1;
      end
      s1_valid_reg <= keep;
      if (keep) begin
        s1_data_reg <= sat;
      end
    end
  end

  lpf_sync_fifo #(
    .width (word_size_out),
    .depth (fifo_depth)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (s1_valid_reg),
    .pop   (sink.out_ready),
    .wdata (s1_data_reg),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A full FIFO always has a head, so out_ready alone decides whether room appears.
  assign drop           = s1_valid_reg && fifo_full && !sink.out_ready;
  assign sink.out_valid = (fifo_count != '0);
  assign sink.Data_out  = fifo_empty ? '0 : fifo_rdata;
  assign overflow       = overflow_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clear_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

`ifdef LPF_DROP_COUNT_EN
  logic [7:0] drop_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count_reg <= 8'd0;
    end else if (drop) begin
      if (drop_count_reg != 8'hFF) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end else if (clear_ovf) begin
      drop_count_reg <= 8'd0;
    end
  end

  assign drop_count = drop_count_reg;
`endif

endmodule
